// File: rtl/cycle_sched_pkg.sv
// Shared types and default constants for the single-resource cycle scheduler.
package cycle_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } sched_state_e;

  localparam int unsigned SCHED_QUOTA_DEF = 3;
  localparam int unsigned SCHED_WDOG_DEF  = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_TASKS = 2,
  localparam int unsigned IDX_W  = $clog2(N_TASKS)
) (
  input  logic [N_TASKS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_TASKS-1:0] pick,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    cand = '0;
    for (int off = int'(N_TASKS) - 1; off >= 0; off--) begin
      cand = IDX_W'((32'(ptr) + 32'(off)) % N_TASKS);
      if (req[cand]) begin
        pick = N_TASKS'(1) << cand;
        idx  = cand;
      end
    end
  end

endmodule

// File: rtl/cycle_sched.sv
// Round-robin task dispatcher with per-cycle completion quota and _rt_* event pulses.
// Optional watchdog on task occupancy: define CYCLE_SCHED_WATCHDOG_EN.
module cycle_sched
  import cycle_sched_pkg::*;
#(
  parameter int unsigned N_TASKS  = 2,
  parameter int unsigned QUOTA    = SCHED_QUOTA_DEF,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned WDOG_MAX = SCHED_WDOG_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_TASKS-1:0] req,
  input  logic [N_TASKS-1:0] long_req,
  input  logic               end_task,
  input  logic               end_of_cycle,
  output logic [N_TASKS-1:0] grant,
  output logic               busy,
  output logic [CNT_W-1:0]   done_count,
  output logic               _rt_sched_short,
  output logic               _rt_sched_long,
  output logic               _rt_end_task,
  output logic               _rt_end_of_cycle,
  output logic               error
);

  localparam int unsigned IDX_W = $clog2(N_TASKS);

  if (N_TASKS < 2 || CNT_W < $clog2(QUOTA + 1) || WDOG_MAX < 1) begin : g_bad_param
    $error("cycle_sched: invalid parameter set");
  end

  sched_state_e       state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n, cur_idx, cur_idx_n;
  logic [N_TASKS-1:0] grant_n, arb_pick;
  logic [IDX_W-1:0]   arb_idx;
  logic [CNT_W-1:0]   done_n;
  logic               busy_n, error_n;
  logic               ss_n, sl_n, et_n, eoc_n;
  logic               quota_met;

`ifdef CYCLE_SCHED_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);
  logic [WDOG_W-1:0] wdog, wdog_n;
`else
  // Watchdog not built: no occupancy counter exists.
`endif

  rr_arbiter #(.N_TASKS(N_TASKS)) u_arb (
    .req  (req),
    .ptr  (ptr),
    .pick (arb_pick),
    .idx  (arb_idx)
  );

  assign quota_met = (done_count >= CNT_W'(QUOTA));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ptr              <= '0;
      cur_idx          <= '0;
      grant            <= '0;
      busy             <= 1'b0;
      done_count       <= '0;
      _rt_sched_short  <= 1'b0;
      _rt_sched_long   <= 1'b0;
      _rt_end_task     <= 1'b0;
      _rt_end_of_cycle <= 1'b0;
      error            <= 1'b0;
`ifdef CYCLE_SCHED_WATCHDOG_EN
      wdog             <= '0;
`endif
    end else begin
      state            <= state_n;
      ptr              <= ptr_n;
      cur_idx          <= cur_idx_n;
      grant            <= grant_n;
      busy             <= busy_n;
      done_count       <= done_n;
      _rt_sched_short  <= ss_n;
      _rt_sched_long   <= sl_n;
      _rt_end_task     <= et_n;
      _rt_end_of_cycle <= eoc_n;
      error            <= error_n;
`ifdef CYCLE_SCHED_WATCHDOG_EN
      wdog             <= wdog_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cur_idx_n = cur_idx;
    grant_n   = grant;
    busy_n    = busy;
    done_n    = done_count;
    error_n   = error;
    ss_n      = 1'b0;
    sl_n      = 1'b0;
    et_n      = 1'b0;
    eoc_n     = 1'b0;
`ifdef CYCLE_SCHED_WATCHDOG_EN
    wdog_n    = wdog;
`endif

    unique case (state)
      IDLE: begin
        if (end_of_cycle) begin
          eoc_n = 1'b1;
          if (quota_met) done_n = '0;
          else           state_n = ERR;
        end else if (end_task) begin
          state_n = ERR;
        end else if (|req) begin
          grant_n   = arb_pick;
          cur_idx_n = arb_idx;
          busy_n    = 1'b1;
          sl_n      = long_req[arb_idx];
          ss_n      = !long_req[arb_idx];
          state_n   = RUN;
`ifdef CYCLE_SCHED_WATCHDOG_EN
          wdog_n    = '0;
`endif
        end
      end
      RUN: begin
        // A boundary strobe wins; a coincident end_task is dropped.
        if (end_of_cycle) begin
          eoc_n = 1'b1;
          if (quota_met) done_n = '0;
          else           state_n = ERR;
        end else if (end_task) begin
          et_n    = 1'b1;
          grant_n = '0;
          busy_n  = 1'b0;
          done_n  = quota_met ? done_count : done_count + CNT_W'(1);
          ptr_n   = (cur_idx == IDX_W'(N_TASKS - 1)) ? '0 : cur_idx + IDX_W'(1);
          state_n = IDLE;
        end
      end
      default: state_n = ERR;
    endcase

`ifdef CYCLE_SCHED_WATCHDOG_EN
    // Only a task still running after this edge ages; end_task leaves RUN and so wins.
    if (state == RUN && state_n == RUN) begin
      if (wdog == WDOG_W'(WDOG_MAX - 1)) state_n = ERR;
      else                               wdog_n  = wdog + WDOG_W'(1);
    end
`endif

    if (state_n == ERR) begin
      grant_n = '0;
      busy_n  = 1'b0;
      error_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_cycle_sched.sv
// Directed, table-driven bench for cycle_sched (N_TASKS=2, QUOTA=3, WDOG_MAX=15).
module tb_cycle_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, long_req;
  logic       end_task, end_of_cycle;
  logic [1:0] grant;
  logic       busy, error;
  logic [3:0] done_count;
  logic       rt_ss, rt_sl, rt_et, rt_eoc;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] P0 = 4'b0000, PS = 4'b1000, PL = 4'b0100, PE = 4'b0010, PC = 4'b0001;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  lng;
    logic        et;
    logic        eoc;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[25];

  always #5 clk = ~clk;

  cycle_sched dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .long_req         (long_req),
    .end_task         (end_task),
    .end_of_cycle     (end_of_cycle),
    .grant            (grant),
    .busy             (busy),
    .done_count       (done_count),
    ._rt_sched_short  (rt_ss),
    ._rt_sched_long   (rt_sl),
    ._rt_end_task     (rt_et),
    ._rt_end_of_cycle (rt_eoc),
    .error            (error)
  );

  function automatic logic [11:0] ex(logic [1:0] g, logic b, logic [3:0] d, logic [3:0] p, logic e);
    return {g, b, d, p, e};
  endfunction

  function automatic vec_t mk(logic [1:0] r, logic [1:0] l, logic t, logic c, logic [11:0] e);
    vec_t v;
    v.req = r; v.lng = l; v.et = t; v.eoc = c; v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {grant, busy, done_count, rt_ss, rt_sl, rt_et, rt_eoc, error};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got grant=%b busy=%b done=%0d rt=%b err=%b, want grant=%b busy=%b done=%0d rt=%b err=%b",
               nm, obs[11:10], obs[9], obs[8:5], obs[4:1], obs[0],
               exp[11:10], exp[9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the next rising edge.
  task automatic cyc(input logic [1:0] r, input logic [1:0] l, input logic t, input logic c);
    @(negedge clk);
    req = r; long_req = l; end_task = t; end_of_cycle = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; long_req = '0; end_task = 1'b0; end_of_cycle = 1'b0;
    #1;
    check("async_reset", ex(2'b00, 0, 0, P0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; long_req = '0; end_task = 1'b0; end_of_cycle = 1'b0;

    tbl[0]  = mk(2'b00, 2'b00, 0, 0, ex(2'b00, 0, 0, P0, 0));
    tbl[1]  = mk(2'b01, 2'b00, 0, 0, ex(2'b01, 1, 0, PS, 0));
    tbl[2]  = mk(2'b00, 2'b00, 1, 0, ex(2'b00, 0, 1, PE, 0));
    tbl[3]  = mk(2'b11, 2'b10, 0, 0, ex(2'b10, 1, 1, PL, 0));
    tbl[4]  = mk(2'b11, 2'b10, 1, 0, ex(2'b00, 0, 2, PE, 0));
    tbl[5]  = mk(2'b11, 2'b10, 0, 0, ex(2'b01, 1, 2, PS, 0));
    tbl[6]  = mk(2'b11, 2'b10, 1, 0, ex(2'b00, 0, 3, PE, 0));
    tbl[7]  = mk(2'b11, 2'b10, 0, 0, ex(2'b10, 1, 3, PL, 0));
    tbl[8]  = mk(2'b11, 2'b10, 1, 0, ex(2'b00, 0, 3, PE, 0));
    tbl[9]  = mk(2'b01, 2'b00, 0, 1, ex(2'b00, 0, 0, PC, 0));
    tbl[10] = mk(2'b01, 2'b00, 0, 0, ex(2'b01, 1, 0, PS, 0));
    tbl[11] = mk(2'b00, 2'b00, 1, 0, ex(2'b00, 0, 1, PE, 0));
    tbl[12] = mk(2'b10, 2'b00, 0, 0, ex(2'b10, 1, 1, PS, 0));
    tbl[13] = mk(2'b00, 2'b00, 1, 0, ex(2'b00, 0, 2, PE, 0));
    tbl[14] = mk(2'b01, 2'b00, 0, 0, ex(2'b01, 1, 2, PS, 0));
    tbl[15] = mk(2'b00, 2'b00, 1, 0, ex(2'b00, 0, 3, PE, 0));
    tbl[16] = mk(2'b10, 2'b00, 0, 0, ex(2'b10, 1, 3, PS, 0));
    tbl[17] = mk(2'b10, 2'b00, 0, 1, ex(2'b10, 1, 0, PC, 0));
    tbl[18] = mk(2'b01, 2'b01, 0, 0, ex(2'b10, 1, 0, P0, 0));
    tbl[19] = mk(2'b00, 2'b00, 1, 0, ex(2'b00, 0, 1, PE, 0));
    tbl[20] = mk(2'b01, 2'b00, 0, 0, ex(2'b01, 1, 1, PS, 0));
    tbl[21] = mk(2'b00, 2'b00, 1, 0, ex(2'b00, 0, 2, PE, 0));
    tbl[22] = mk(2'b00, 2'b00, 0, 1, ex(2'b00, 0, 2, PC, 1));
    tbl[23] = mk(2'b11, 2'b00, 0, 0, ex(2'b00, 0, 2, P0, 1));
    tbl[24] = mk(2'b00, 2'b00, 1, 1, ex(2'b00, 0, 2, P0, 1));

    #12;
    check("reset_state", ex(2'b00, 0, 0, P0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].req, tbl[i].lng, tbl[i].et, tbl[i].eoc);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Recovery from ERR, then a spurious completion in IDLE.
    do_reset();
    cyc(2'b01, 2'b00, 0, 0);
    check("regrant_after_reset", ex(2'b01, 1, 0, PS, 0));
    cyc(2'b00, 2'b00, 1, 0);
    check("regrant_end", ex(2'b00, 0, 1, PE, 0));
    cyc(2'b00, 2'b00, 1, 0);
    check("spurious_end", ex(2'b00, 0, 1, P0, 1));

    // Reset in the middle of a task clears grant without an end event.
    do_reset();
    cyc(2'b10, 2'b10, 0, 0);
    check("grant_long_idx1", ex(2'b10, 1, 0, PL, 0));
    do_reset();

    // Task held beyond the watchdog limit.
    cyc(2'b01, 2'b00, 0, 0);
    check("wdog_grant", ex(2'b01, 1, 0, PS, 0));
    for (int i = 0; i < 14; i++) cyc(2'b00, 2'b00, 0, 0);
    check("wdog_14", ex(2'b01, 1, 0, P0, 0));
    cyc(2'b00, 2'b00, 0, 0);
`ifdef CYCLE_SCHED_WATCHDOG_EN
    check("wdog_15", ex(2'b00, 0, 0, P0, 1));
    cyc(2'b00, 2'b00, 1, 0);
    check("wdog_absorb", ex(2'b00, 0, 0, P0, 1));
`else
    check("wdog_15", ex(2'b01, 1, 0, P0, 0));
    cyc(2'b00, 2'b00, 1, 0);
    check("wdog_end", ex(2'b00, 0, 1, PE, 0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
